// File: rtl/serial_adder_n_if.sv
// Handshake/result bundle for serial_adder_n. Sized by WIDTH so several
// differently-sized adders can coexist in one system.
interface serial_adder_n_if #(
   parameter int WIDTH = 8
);
   // Handshake: start acts as valid and ~busy as ready. A request transfers
   // on a rising edge where start=1 and busy=0, which includes the done cycle.
   // done pulses for one cycle once the transferred request has completed.
   logic             start;
   logic             sub;
   logic             cin;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;
   logic [1:0]       dbg_state;

   modport master (
      output start, sub, cin, a, b,
      input  busy, done, sum, cout, ovf, dbg_state
   );

   modport slave (
      input  start, sub, cin, a, b,
      output busy, done, sum, cout, ovf, dbg_state
   );
endinterface

// File: rtl/serial_adder_n.sv
// Multi-cycle adder/subtractor: one SLICE-bit ripple stage per clock,
// least-significant slice first, carry kept in a register between steps.
module serial_adder_n #(
   parameter int WIDTH = 8,
   parameter int SLICE = 1
) (
   input logic              clk,
   input logic              rst_n,
   serial_adder_n_if.slave  bus
);
   localparam int STEPS = WIDTH / SLICE;
   localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
   localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] sum_sr;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             busy_r;
   logic             done_r;
   logic [WIDTH-1:0] sum_r;
   logic             cout_r;
   logic             ovf_r;

   logic [SLICE:0]   slice_sum;
   logic [WIDTH-1:0] sum_next;
   logic             msb_cin;

   assign slice_sum = {1'b0, a_sr[SLICE-1:0]} + {1'b0, b_sr[SLICE-1:0]}
                    + {{SLICE{1'b0}}, carry};
   // New slice enters at the top; after STEPS shifts the result is aligned.
   assign sum_next  = (sum_sr >> SLICE) | (WIDTH'(slice_sum[SLICE-1:0]) << (WIDTH - SLICE));
   // Carry into the slice MSB recovered from its sum bit: s = a ^ b ^ cin.
   assign msb_cin   = a_sr[SLICE-1] ^ b_sr[SLICE-1] ^ slice_sum[SLICE-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         a_sr   <= '0;
         b_sr   <= '0;
         sum_sr <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
         sum_r  <= '0;
         cout_r <= 1'b0;
         ovf_r  <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done_r <= 1'b0;
               if (bus.start) begin
                  // Subtract is a + ~b + ~cin, so invert B and the carry-in here.
                  a_sr   <= bus.a;
                  b_sr   <= bus.b ^ {WIDTH{bus.sub}};
                  carry  <= bus.cin ^ bus.sub;
                  cnt    <= '0;
                  busy_r <= 1'b1;
                  state  <= RUN;
               end else begin
                  state  <= IDLE;
               end
            end
            RUN: begin
               sum_sr <= sum_next;
               carry  <= slice_sum[SLICE];
               a_sr   <= a_sr >> SLICE;
               b_sr   <= b_sr >> SLICE;
               cnt    <= cnt + 1'b1;
               if (cnt == LAST) begin
                  sum_r  <= sum_next;
                  cout_r <= slice_sum[SLICE];
                  ovf_r  <= msb_cin ^ slice_sum[SLICE];
                  busy_r <= 1'b0;
                  done_r <= 1'b1;
                  state  <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy      = busy_r;
   assign bus.done      = done_r;
   assign bus.sum       = sum_r;
   assign bus.cout      = cout_r;
   assign bus.ovf       = ovf_r;
   assign bus.dbg_state = state;
endmodule

// File: tb/tb_serial_adder_n.sv
// Bench for serial_adder_n: one 8/1 instance plus 16/4, 16/16 and 16/1
// instances driven together for the parameter sweep.
module tb_serial_adder_n;
   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   // Expected results packed as {cout, ovf, sum[15:0]}; 8-bit sums zero-extended.
   logic [17:0] exp_q8[$];
   logic [17:0] exp_qa[$];
   logic [17:0] exp_qb[$];
   logic [17:0] exp_qc[$];
   int          done_cnt8;

   serial_adder_n_if #(.WIDTH(8))  b8();
   serial_adder_n_if #(.WIDTH(16)) ba();
   serial_adder_n_if #(.WIDTH(16)) bb();
   serial_adder_n_if #(.WIDTH(16)) bc();

   serial_adder_n #(.WIDTH(8),  .SLICE(1))  u8 (.clk(clk), .rst_n(rst_n), .bus(b8));
   serial_adder_n #(.WIDTH(16), .SLICE(4))  ua (.clk(clk), .rst_n(rst_n), .bus(ba));
   serial_adder_n #(.WIDTH(16), .SLICE(16)) ub (.clk(clk), .rst_n(rst_n), .bus(bb));
   serial_adder_n #(.WIDTH(16), .SLICE(1))  uc (.clk(clk), .rst_n(rst_n), .bus(bc));

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [17:0] model(input int w, input logic s, input logic c,
                                         input logic [15:0] aa, input logic [15:0] bv);
      logic [16:0] full;
      logic [15:0] mask, bx, sm, am;
      logic        co, ov;
      mask = (w == 16) ? 16'hFFFF : 16'h00FF;
      am   = aa & mask;
      bx   = (s ? ~bv : bv) & mask;
      full = {1'b0, am} + {1'b0, bx} + {16'b0, c ^ s};
      sm   = full[15:0] & mask;
      co   = full[w];
      ov   = (am[w-1] == bx[w-1]) && (sm[w-1] != am[w-1]);
      return {co, ov, sm};
   endfunction

   // ---------------- scoreboard monitors ----------------
   always @(negedge clk) begin
      if (b8.done) begin
         done_cnt8++;
         if (exp_q8.size() == 0) begin
            checks++; errors++;
            $display("FAIL d8 done without request: sum %0h", b8.sum);
         end else begin
            chk("d8 result", {14'b0, b8.cout, b8.ovf, 8'h00, b8.sum}, {14'b0, exp_q8.pop_front()});
            chk("d8 busy in done", {31'b0, b8.busy}, 32'd0);
         end
      end
   end

   always @(negedge clk) begin
      if (ba.done) begin
         if (exp_qa.size() == 0) begin
            checks++; errors++;
            $display("FAIL d16s4 done without request: sum %0h", ba.sum);
         end else chk("d16s4 result", {14'b0, ba.cout, ba.ovf, ba.sum}, {14'b0, exp_qa.pop_front()});
      end
   end

   always @(negedge clk) begin
      if (bb.done) begin
         if (exp_qb.size() == 0) begin
            checks++; errors++;
            $display("FAIL d16s16 done without request: sum %0h", bb.sum);
         end else chk("d16s16 result", {14'b0, bb.cout, bb.ovf, bb.sum}, {14'b0, exp_qb.pop_front()});
      end
   end

   always @(negedge clk) begin
      if (bc.done) begin
         if (exp_qc.size() == 0) begin
            checks++; errors++;
            $display("FAIL d16s1 done without request: sum %0h", bc.sum);
         end else chk("d16s1 result", {14'b0, bc.cout, bc.ovf, bc.sum}, {14'b0, exp_qc.pop_front()});
      end
   end

   // ---------------- driver tasks ----------------
   // Drives one 8-bit request, then checks latency and busy length.
   task automatic op8(input bit wait_first, input logic s, input logic c,
                      input logic [7:0] aa, input logic [7:0] bv, input logic [17:0] exp);
      int lat;
      int bcnt;
      if (wait_first) @(negedge clk);
      b8.start = 1'b1; b8.sub = s; b8.cin = c; b8.a = aa; b8.b = bv;
      exp_q8.push_back(exp);
      @(negedge clk);
      b8.start = 1'b0;
      lat = 0; bcnt = 0;
      while (!b8.done && lat < 60) begin
         if (b8.busy) bcnt++;
         @(negedge clk);
         lat++;
      end
      chk("d8 latency", lat, 8);
      chk("d8 busy cycles", bcnt, 8);
   endtask

   task automatic op16(input logic s, input logic c, input logic [15:0] aa,
                       input logic [15:0] bv, input logic [17:0] exp);
      int lat, la, lb, lc;
      @(negedge clk);
      ba.start = 1'b1; ba.sub = s; ba.cin = c; ba.a = aa; ba.b = bv;
      bb.start = 1'b1; bb.sub = s; bb.cin = c; bb.a = aa; bb.b = bv;
      bc.start = 1'b1; bc.sub = s; bc.cin = c; bc.a = aa; bc.b = bv;
      exp_qa.push_back(exp); exp_qb.push_back(exp); exp_qc.push_back(exp);
      @(negedge clk);
      ba.start = 1'b0; bb.start = 1'b0; bc.start = 1'b0;
      lat = 0; la = -1; lb = -1; lc = -1;
      while (lat < 60 && (la < 0 || lb < 0 || lc < 0)) begin
         if (ba.done && la < 0) la = lat;
         if (bb.done && lb < 0) lb = lat;
         if (bc.done && lc < 0) lc = lat;
         if (la < 0 || lb < 0 || lc < 0) begin
            @(negedge clk);
            lat++;
         end
      end
      chk("d16s4 latency", la, 4);
      chk("d16s16 latency", lb, 1);
      chk("d16s1 latency", lc, 16);
      @(negedge clk);
   endtask

   typedef struct {
      logic       sub;
      logic       cin;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] sum;
      logic       cout;
      logic       ovf;
   } vec_t;

   vec_t tbl[10];

   // ---------------- main sequence ----------------
   initial begin
      int dc;
      logic [7:0]  ra, rb;
      logic [15:0] wa, wb;
      logic        rs, rc;

      checks = 0; errors = 0; done_cnt8 = 0;
      tbl[0] = '{1'b0, 1'b0, 8'd100, 8'd27,  8'd127,  1'b0, 1'b0};
      tbl[1] = '{1'b0, 1'b0, 8'hFF,  8'h01,  8'h00,   1'b1, 1'b0};
      tbl[2] = '{1'b0, 1'b0, 8'h7F,  8'h01,  8'h80,   1'b0, 1'b1};
      tbl[3] = '{1'b0, 1'b1, 8'hFF,  8'hFF,  8'hFF,   1'b1, 1'b0};
      tbl[4] = '{1'b1, 1'b0, 8'd5,   8'd7,   8'hFE,   1'b0, 1'b0};
      tbl[5] = '{1'b1, 1'b0, 8'h80,  8'h01,  8'h7F,   1'b1, 1'b1};
      tbl[6] = '{1'b1, 1'b1, 8'd9,   8'd3,   8'd5,    1'b1, 1'b0};
      tbl[7] = '{1'b0, 1'b0, 8'h80,  8'h80,  8'h00,   1'b1, 1'b1};
      tbl[8] = '{1'b1, 1'b0, 8'h00,  8'h00,  8'h00,   1'b1, 1'b0};
      tbl[9] = '{1'b0, 1'b1, 8'h3C,  8'h0F,  8'h4C,   1'b0, 1'b0};

      rst_n = 1'b0;
      b8.start = 0; b8.sub = 0; b8.cin = 0; b8.a = '0; b8.b = '0;
      ba.start = 0; ba.sub = 0; ba.cin = 0; ba.a = '0; ba.b = '0;
      bb.start = 0; bb.sub = 0; bb.cin = 0; bb.a = '0; bb.b = '0;
      bc.start = 0; bc.sub = 0; bc.cin = 0; bc.a = '0; bc.b = '0;
      #3;
      chk("reset busy", {31'b0, b8.busy}, 0);
      chk("reset done", {31'b0, b8.done}, 0);
      chk("reset outputs", {22'b0, b8.cout, b8.ovf, b8.sum}, 0);
      chk("reset state", {30'b0, b8.dbg_state}, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++)
         op8(1'b1, tbl[i].sub, tbl[i].cin, tbl[i].a, tbl[i].b,
             {tbl[i].cout, tbl[i].ovf, 8'h00, tbl[i].sum});

      for (int i = 0; i < 6; i++) begin
         ra = 8'($urandom_range(0, 255)); rb = 8'($urandom_range(0, 255));
         rs = 1'($urandom_range(0, 1));   rc = 1'($urandom_range(0, 1));
         op8(1'b1, rs, rc, ra, rb, model(8, rs, rc, {8'h00, ra}, {8'h00, rb}));
      end

      // start pulses with new operands during RUN must be ignored
      @(negedge clk);
      dc = done_cnt8;
      b8.start = 1; b8.sub = 0; b8.cin = 0; b8.a = 8'h21; b8.b = 8'h13;
      exp_q8.push_back({2'b00, 8'h00, 8'h34});
      @(negedge clk); b8.start = 0;
      @(negedge clk); b8.start = 1; b8.sub = 1; b8.a = 8'hFF; b8.b = 8'hFF;
      @(negedge clk); b8.start = 0; b8.a = 8'h00;
      repeat (2) @(negedge clk);
      b8.start = 1; b8.cin = 1; b8.a = 8'h55; b8.b = 8'hAA;
      @(negedge clk); b8.start = 0; b8.sub = 0; b8.cin = 0;
      repeat (16) @(negedge clk);
      chk("ignored start: done count", done_cnt8 - dc, 1);

      // back-to-back: second request issued in the done cycle
      op8(1'b1, 1'b0, 1'b0, 8'h40, 8'h25, {2'b00, 8'h00, 8'h65});
      op8(1'b0, 1'b1, 1'b0, 8'h40, 8'h25, {2'b10, 8'h00, 8'h1B});

      // asynchronous reset during RUN step 4
      @(negedge clk);
      b8.start = 1; b8.sub = 0; b8.cin = 0; b8.a = 8'h0F; b8.b = 8'h01;
      @(negedge clk); b8.start = 0;
      repeat (4) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mid reset busy", {31'b0, b8.busy}, 0);
      chk("mid reset done", {31'b0, b8.done}, 0);
      chk("mid reset outputs", {22'b0, b8.cout, b8.ovf, b8.sum}, 0);
      chk("mid reset state", {30'b0, b8.dbg_state}, 0);
      dc = done_cnt8;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      chk("no done after abort", done_cnt8 - dc, 0);
      op8(1'b1, 1'b0, 1'b0, 8'h12, 8'h34, {2'b00, 8'h00, 8'h46});

      // WIDTH=16 sweep over SLICE=4, 16, 1
      op16(1'b0, 1'b0, 16'hFFFF, 16'h0001, {1'b1, 1'b0, 16'h0000});
      op16(1'b1, 1'b0, 16'h7FFF, 16'hFFFF, {1'b0, 1'b1, 16'h8000});
      for (int i = 0; i < 6; i++) begin
         wa = 16'($urandom_range(0, 65535)); wb = 16'($urandom_range(0, 65535));
         rs = 1'($urandom_range(0, 1));      rc = 1'($urandom_range(0, 1));
         op16(rs, rc, wa, wb, model(16, rs, rc, wa, wb));
      end

      repeat (4) @(negedge clk);
      chk("d8 queue drained", exp_q8.size(), 0);
      chk("d16s4 queue drained", exp_qa.size(), 0);
      chk("d16s16 queue drained", exp_qb.size(), 0);
      chk("d16s1 queue drained", exp_qc.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
